// File: rtl/mem_arb_pkg.sv
// Shared types for the dual-port syncram arbiter.
// Read-return tags carry the issuing requester id.
package mem_arb_pkg;

   localparam int MEM_LAT_DEF = 2;
   localparam int TAG_ID_W    = 3;

   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-winner round-robin picker.
// Scans requesters cyclically from rr_ptr; first hit is win0, second is win1.
module mem_arb_rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_rr_ptr,
   output logic               o_win0_vld,
   output logic [ID_W-1:0]    o_win0_id,
   output logic               o_win1_vld,
   output logic [ID_W-1:0]    o_win1_id
);

   logic [ID_W-1:0] idx;

   always_comb begin
      o_win0_vld = 1'b0;
      o_win0_id  = '0;
      o_win1_vld = 1'b0;
      o_win1_id  = '0;
      idx        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ID_W'((int'(i_rr_ptr) + i) % NUM_REQ);
         if (i_req[idx]) begin
            if (!o_win0_vld) begin
               o_win0_vld = 1'b1;
               o_win0_id  = idx;
            end else if (!o_win1_vld) begin
               o_win1_vld = 1'b1;
               o_win1_id  = idx;
            end
         end
      end
   end

endmodule

// File: rtl/syncram_port_arbiter.sv
// Shares a dual-port syncram between NUM_REQ requesters, two grants per cycle,
// and routes each read's data back to its issuer MEM_LAT cycles after grant.
module syncram_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int AW      = 10,
   parameter int DW      = 32,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NUM_REQ-1:0]    i_req,
   input  logic [NUM_REQ-1:0]    i_we,
   input  logic [NUM_REQ*AW-1:0] i_addr,
   input  logic [NUM_REQ*DW-1:0] i_wdata,
   output logic [NUM_REQ-1:0]    o_gnt,
   output logic [NUM_REQ-1:0]    o_rvalid,
   output logic [NUM_REQ*DW-1:0] o_rdata,
   output logic [AW-1:0]         o_addr_a,
   output logic [AW-1:0]         o_addr_b,
   output logic [DW-1:0]         o_data_a,
   output logic [DW-1:0]         o_data_b,
   output logic                  o_rden_a,
   output logic                  o_rden_b,
   output logic                  o_wren_a,
   output logic                  o_wren_b,
   input  logic [DW-1:0]         i_q_a,
   input  logic [DW-1:0]         i_q_b
);

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]   addr_a_q, addr_a_d;
   logic [AW-1:0]   addr_b_q, addr_b_d;
   logic [DW-1:0]   data_a_q, data_a_d;
   logic [DW-1:0]   data_b_q, data_b_d;
   tag_t            tag_a_q [MEM_LAT];
   tag_t            tag_a_d [MEM_LAT];
   tag_t            tag_b_q [MEM_LAT];
   tag_t            tag_b_d [MEM_LAT];

   logic            w0_vld, w1_vld;
   logic [ID_W-1:0] w0_id, w1_id;
   logic [AW-1:0]   a0, a1;
   logic [DW-1:0]   d0, d1;
   logic            we0, we1;
   logic            conflict, b_go;
   logic [ID_W-1:0] last_id;
   logic [ID_W-1:0] ret_a_id, ret_b_id;

   mem_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .i_req      (i_req),
      .i_rr_ptr   (rr_ptr_q),
      .o_win0_vld (w0_vld),
      .o_win0_id  (w0_id),
      .o_win1_vld (w1_vld),
      .o_win1_id  (w1_id)
   );

   always_comb begin
      a0  = i_addr[w0_id*AW +: AW];
      a1  = i_addr[w1_id*AW +: AW];
      d0  = i_wdata[w0_id*DW +: DW];
      d1  = i_wdata[w1_id*DW +: DW];
      we0 = i_we[w0_id];
      we1 = i_we[w1_id];
      // Second pick waits if it could race the first on one address.
      conflict = (a0 == a1) && (we0 || we1);
      b_go     = w1_vld && !conflict;
      last_id  = b_go ? w1_id : w0_id;
      o_gnt = '0;
      if (w0_vld) o_gnt[w0_id] = 1'b1;
      if (b_go)   o_gnt[w1_id] = 1'b1;
      rr_ptr_d = rr_ptr_q;
      if (w0_vld)
         rr_ptr_d = ID_W'((int'(last_id) + 1) % NUM_REQ);
   end

   always_comb begin
      addr_a_d = addr_a_q;
      data_a_d = data_a_q;
      addr_b_d = addr_b_q;
      data_b_d = data_b_q;
      if (w0_vld) begin
         addr_a_d = a0;
         data_a_d = d0;
      end
      if (b_go) begin
         addr_b_d = a1;
         data_b_d = d1;
      end
      o_addr_a = addr_a_d;
      o_data_a = data_a_d;
      o_addr_b = addr_b_d;
      o_data_b = data_b_d;
      o_rden_a = w0_vld && !we0;
      o_wren_a = w0_vld && we0;
      o_rden_b = b_go && !we1;
      o_wren_b = b_go && we1;
   end

   always_comb begin
      tag_a_d[0].vld = w0_vld && !we0;
      tag_a_d[0].id  = TAG_ID_W'(w0_id);
      tag_b_d[0].vld = b_go && !we1;
      tag_b_d[0].id  = TAG_ID_W'(w1_id);
      for (int i = 1; i < MEM_LAT; i++) begin
         tag_a_d[i] = tag_a_q[i-1];
         tag_b_d[i] = tag_b_q[i-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr_q <= '0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         data_a_q <= '0;
         data_b_q <= '0;
         for (int i = 0; i < MEM_LAT; i++) begin
            tag_a_q[i] <= '0;
            tag_b_q[i] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         data_a_q <= data_a_d;
         data_b_q <= data_b_d;
         for (int i = 0; i < MEM_LAT; i++) begin
            tag_a_q[i] <= tag_a_d[i];
            tag_b_q[i] <= tag_b_d[i];
         end
      end
   end

   assign ret_a_id = tag_a_q[MEM_LAT-1].id[ID_W-1:0];
   assign ret_b_id = tag_b_q[MEM_LAT-1].id[ID_W-1:0];

   always_comb begin
      o_rvalid = '0;
      o_rdata  = '0;
      if (tag_a_q[MEM_LAT-1].vld) begin
         o_rvalid[ret_a_id]           = 1'b1;
         o_rdata[ret_a_id*DW +: DW]   = i_q_a;
      end
      if (tag_b_q[MEM_LAT-1].vld) begin
         o_rvalid[ret_b_id]           = 1'b1;
         o_rdata[ret_b_id*DW +: DW]   = i_q_b;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n && tag_a_q[MEM_LAT-1].vld && tag_b_q[MEM_LAT-1].vld)
         assert (tag_a_q[MEM_LAT-1].id != tag_b_q[MEM_LAT-1].id)
            else $error("both ports return to one requester");
   end

endmodule

// File: tb/tb_syncram_port_arbiter.sv
// Bench for syncram_port_arbiter paired with a 2-cycle dual-port syncram model.
// Directed vectors, hand sequences, then random traffic against a reference model.
module tb_syncram_port_arbiter;

   localparam int NR = 4;
   localparam int AW = 10;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NR-1:0]   req = '0, we = '0;
   logic [NR*AW-1:0] addr = '0;
   logic [NR*DW-1:0] wdata = '0;
   logic [NR-1:0]   gnt, rvalid;
   logic [NR*DW-1:0] rdata;
   logic [AW-1:0]   addr_a, addr_b;
   logic [DW-1:0]   data_a, data_b, q_a, q_b;
   logic            rden_a, rden_b, wren_a, wren_b;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   syncram_port_arbiter #(
      .NUM_REQ (NR), .ID_W (2), .AW (AW), .DW (DW), .MEM_LAT (2)
   ) dut (
      .i_clk    (clk),    .i_rst_n  (rst_n),
      .i_req    (req),    .i_we     (we),
      .i_addr   (addr),   .i_wdata  (wdata),
      .o_gnt    (gnt),    .o_rvalid (rvalid),
      .o_rdata  (rdata),
      .o_addr_a (addr_a), .o_addr_b (addr_b),
      .o_data_a (data_a), .o_data_b (data_b),
      .o_rden_a (rden_a), .o_rden_b (rden_b),
      .o_wren_a (wren_a), .o_wren_b (wren_b),
      .i_q_a    (q_a),    .i_q_b    (q_b)
   );

   // syncram: address registered, then q registered
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0] ra_a, ra_b;
   always @(posedge clk) begin
      if (wren_a) mem[addr_a] <= data_a;
      if (wren_b) mem[addr_b] <= data_b;
      ra_a <= addr_a;
      ra_b <= addr_b;
      q_a  <= mem[ra_a];
      q_b  <= mem[ra_b];
   end

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  we;
      logic [39:0] addr;
      logic [3:0]  gnt;
      logic [1:0]  pa;
      logic [1:0]  pb;
      logic [9:0]  aa;
      logic [9:0]  ab;
   } vec_t;
   vec_t tbl [10];

   typedef struct {
      int          due;
      int          id;
      logic [31:0] d;
   } ret_t;
   ret_t rq [$];

   logic [DW-1:0]   ref_mem [0:(1<<AW)-1];
   logic [127:0]    WD;

   function automatic logic [39:0] pk(int a0, int a1, int a2, int a3);
      return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
   endfunction

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      req   = '0;
      we    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic rd_check(input int id, input int a,
                           input logic [31:0] exp, input string nm);
      req = '0;
      req[id] = 1'b1;
      we = '0;
      addr[id*AW +: AW] = 10'(a);
      @(negedge clk);
      check({nm, "_gnt"}, {gnt, rden_a, wren_a, addr_a},
            {4'(1 << id), 1'b1, 1'b0, 10'(a)});
      tick();
      req = '0;
      @(negedge clk);
      check({nm, "_c1"}, 128'(rvalid), 128'h0);
      tick();
      @(negedge clk);
      check({nm, "_ret"}, {rvalid, rdata[id*DW +: DW]},
            {4'(1 << id), exp});
      tick();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hA0 + i;
   end

   int          f0, f1, n, cyc;
   logic [3:0]  exp_g, exp_rv, p_req, p_we;
   logic [127:0] exp_rd, act_rd;
   logic [9:0]  p_addr [4];
   logic [31:0] p_wd [4];

   initial begin
      WD = {32'h44, 32'h33, 32'h22, 32'h11};
      tbl[0] = '{4'b1111, 4'b0000, pk(16,17,18,19), 4'b0011, 2'b10, 2'b10, 10'd16, 10'd17};
      tbl[1] = '{4'b1111, 4'b0000, pk(16,17,18,19), 4'b1100, 2'b10, 2'b10, 10'd18, 10'd19};
      tbl[2] = '{4'b1111, 4'b0000, pk(16,17,18,19), 4'b0011, 2'b10, 2'b10, 10'd16, 10'd17};
      tbl[3] = '{4'b0000, 4'b0000, pk(16,17,18,19), 4'b0000, 2'b00, 2'b00, 10'd16, 10'd17};
      tbl[4] = '{4'b0001, 4'b0000, pk(16,17,18,19), 4'b0001, 2'b10, 2'b00, 10'd16, 10'd17};
      tbl[5] = '{4'b0100, 4'b0000, pk(16,17,18,19), 4'b0100, 2'b10, 2'b00, 10'd18, 10'd17};
      tbl[6] = '{4'b1001, 4'b0000, pk(16,17,18,19), 4'b1001, 2'b10, 2'b10, 10'd19, 10'd16};
      tbl[7] = '{4'b1010, 4'b0000, pk(16,17,18,19), 4'b1010, 2'b10, 2'b10, 10'd17, 10'd19};
      tbl[8] = '{4'b0011, 4'b0011, pk(7,7,7,7),     4'b0001, 2'b01, 2'b00, 10'd7,  10'd19};
      tbl[9] = '{4'b0010, 4'b0010, pk(7,7,7,7),     4'b0010, 2'b01, 2'b00, 10'd7,  10'd19};

      wdata = WD;
      do_reset();
      @(negedge clk);
      check("reset", {gnt, rvalid, rden_a, wren_a, rden_b, wren_b,
                      addr_a, addr_b, data_a, data_b, rdata[63:0]},
            128'h0);
      check("reset_rd", rdata, 128'h0);
      tick();

      rd_check(0, 5, 32'hA5, "t1");

      do_reset();
      for (int i = 0; i < 10; i++) begin
         req  = tbl[i].req;
         we   = tbl[i].we;
         addr = tbl[i].addr;
         @(negedge clk);
         check($sformatf("tbl%0d", i),
               {gnt, rden_a, wren_a, rden_b, wren_b, addr_a, addr_b},
               {tbl[i].gnt, tbl[i].pa, tbl[i].pb, tbl[i].aa, tbl[i].ab});
         tick();
      end
      req = '0;
      tick();
      rd_check(2, 7, 32'h22, "t3");

      do_reset();
      req = 4'b1100;
      we = 4'b0100;
      addr = pk(0, 0, 9, 9);
      @(negedge clk);
      check("t4_c0", {gnt, wren_a, addr_a, data_a, rden_b, wren_b},
            {4'b0100, 1'b1, 10'd9, 32'h33, 1'b0, 1'b0});
      tick();
      req = 4'b1000;
      @(negedge clk);
      check("t4_c1", {gnt, rden_a, addr_a}, {4'b1000, 1'b1, 10'd9});
      tick();
      req = '0;
      @(negedge clk);
      check("t4_c2", 128'(rvalid), 128'h0);
      tick();
      @(negedge clk);
      check("t4_ret", {rvalid, rdata[127:96]}, {4'b1000, 32'h33});
      tick();

      do_reset();
      req = 4'b1111;
      we = '0;
      addr = pk(1, 2, 3, 4);
      @(negedge clk);
      check("t5_g0", 128'(gnt), 128'(4'b0011));
      tick();
      @(negedge clk);
      check("t5_g1", 128'(gnt), 128'(4'b1100));
      tick();
      rst_n = 1'b0;
      req = '0;
      @(negedge clk);
      check("t5_rst", 128'(rvalid), 128'h0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("t5_drop%0d", i), 128'(rvalid), 128'h0);
         tick();
      end
      req = 4'b1111;
      @(negedge clk);
      check("t5_rr0", 128'(gnt), 128'(4'b0011));
      tick();

      do_reset();
      tick();
      tick();
      ref_mem = mem;
      p_req = '0;
      p_we = '0;
      f1 = 0;
      n = 0;
      f0 = 0;
      cyc = 0;
      begin
         int rr_m;
         rr_m = 0;
         for (cyc = 0; cyc < 2000; cyc++) begin
            for (int k = 0; k < NR; k++) begin
               if (!p_req[k] && cyc < 1990 && $urandom_range(0, 1) == 1) begin
                  p_req[k]  = 1'b1;
                  p_we[k]   = ($urandom_range(0, 2) == 0);
                  p_addr[k] = 10'($urandom_range(0, 7));
                  p_wd[k]   = $urandom;
               end
               addr[k*AW +: AW]  = p_addr[k];
               wdata[k*DW +: DW] = p_wd[k];
            end
            req = p_req;
            we  = p_we;
            n = 0;
            for (int i = 0; i < NR; i++) begin
               int k;
               k = (rr_m + i) % NR;
               if (p_req[k]) begin
                  if (n == 0) f0 = k;
                  else if (n == 1) f1 = k;
                  n++;
               end
            end
            exp_g = '0;
            if (n >= 1) exp_g[f0] = 1'b1;
            if (n >= 2 && !(p_addr[f0] == p_addr[f1] && (p_we[f0] || p_we[f1])))
               exp_g[f1] = 1'b1;
            exp_rv = '0;
            exp_rd = '0;
            foreach (rq[j]) begin
               if (rq[j].due == cyc) begin
                  exp_rv[rq[j].id] = 1'b1;
                  exp_rd[rq[j].id*DW +: DW] = rq[j].d;
               end
            end
            @(negedge clk);
            act_rd = '0;
            for (int k = 0; k < NR; k++)
               if (exp_rv[k]) act_rd[k*DW +: DW] = rdata[k*DW +: DW];
            check("rnd_gnt", 128'(gnt), 128'(exp_g));
            check("rnd_rv", 128'(rvalid), 128'(exp_rv));
            check("rnd_rd", act_rd, exp_rd);
            for (int k = 0; k < NR; k++) begin
               if (exp_g[k]) begin
                  if (p_we[k]) ref_mem[p_addr[k]] = p_wd[k];
                  else rq.push_back('{cyc + 2, k, ref_mem[p_addr[k]]});
                  p_req[k] = 1'b0;
               end
            end
            if (n >= 1) rr_m = ((exp_g[f1] && n >= 2 ? f1 : f0) + 1) % NR;
            while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
